// File: rtl/vga_console_write_arbiter.sv
// AHB-Lite master sharing the VGA text-console character register between two
// byte-stream requesters, with round-robin grant, an idle gap after each write, and write/error counters.
module vga_console_write_arbiter #(
  parameter logic [31:0] VGA_ADDR = 32'h5000_0000,
  parameter int          MIN_GAP  = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy,
  output logic [15:0] wr_count,
  output logic [7:0]  err_count,
  output logic        err_pulse,
  output logic [1:0]  state_dbg
);

  // Handshake: a character moves when reqN_valid && reqN_ready are both high at a
  // rising HCLK edge; ready is only offered in IDLE and never to both requesters at once.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [7:0] GAP_LOAD = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;

  state_t     state, state_nxt;
  logic       last_grant;
  logic [7:0] char_q;
  logic [7:0] gap_cnt;
  logic       grant0, grant1;
  logic       accept;

  // last_grant==1 means requester 1 went last, so requester 0 wins a tie.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    HTRANS     = 2'b00;
    HWRITE     = 1'b0;
    HSIZE      = 3'b000;
    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) state_nxt = ADDR;
      end
      ADDR: begin
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HSIZE  = 3'b010;
        if (HREADY) state_nxt = DATA;
      end
      DATA: begin
        if (HREADY) state_nxt = (MIN_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == 8'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = req0_ready || req1_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      char_q     <= 8'd0;
      gap_cnt    <= 8'd0;
      HADDR      <= 32'd0;
      HWDATA     <= 32'd0;
      wr_count   <= 16'd0;
      err_count  <= 8'd0;
      err_pulse  <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_pulse <= 1'b0;
      if (accept) begin
        char_q     <= req0_ready ? req0_data : req1_data;
        last_grant <= req1_ready;
        HADDR      <= VGA_ADDR;
      end
      if (state == ADDR && HREADY) HWDATA <= {24'd0, char_q};
      // An error response drops the character: no retry and no write count.
      if (state == DATA && HREADY) begin
        gap_cnt <= GAP_LOAD;
        if (HRESP) begin
          err_pulse <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          wr_count <= wr_count + 16'd1;
        end
      end
      if (state == GAP && gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_console_write_arbiter.sv
// Bench for vga_console_write_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, and randomized traffic.
module tb_vga_console_write_arbiter;

  localparam logic [31:0] VGA = 32'h5000_0000;
  localparam int          GAP = 2;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_data = 8'h00, req1_data = 8'h00;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  logic        req0_ready, req1_ready, HWRITE, busy, err_pulse;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS, state_dbg;
  logic [2:0]  HSIZE;
  logic [15:0] wr_count;
  logic [7:0]  err_count;

  logic        g0_valid = 1'b0;
  logic        g0_r0_ready, g0_r1_ready, g0_hwrite, g0_busy, g0_err_pulse;
  logic [31:0] g0_haddr, g0_hwdata;
  logic [1:0]  g0_htrans, g0_state;
  logic [2:0]  g0_hsize;
  logic [15:0] g0_wr_count;
  logic [7:0]  g0_err_count;

  vga_console_write_arbiter #(.VGA_ADDR(VGA), .MIN_GAP(GAP)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .busy(busy), .wr_count(wr_count),
    .err_count(err_count), .err_pulse(err_pulse), .state_dbg(state_dbg)
  );

  vga_console_write_arbiter #(.VGA_ADDR(VGA), .MIN_GAP(0)) dut_g0 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0_valid(1'b0), .req0_data(8'h00), .req0_ready(g0_r0_ready),
    .req1_valid(g0_valid), .req1_data(8'h42), .req1_ready(g0_r1_ready),
    .HADDR(g0_haddr), .HTRANS(g0_htrans), .HWRITE(g0_hwrite), .HSIZE(g0_hsize), .HWDATA(g0_hwdata),
    .HREADY(1'b1), .HRESP(1'b0), .busy(g0_busy), .wr_count(g0_wr_count),
    .err_count(g0_err_count), .err_pulse(g0_err_pulse), .state_dbg(g0_state)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: one character in flight, address/data progress flags, gap countdown
  bit          m_have = 0, m_addr_sent = 0, m_last = 1, m_pulse = 0;
  int          m_gap = 0, m_wr = 0, m_err = 0;
  logic [7:0]  m_char = 8'h00;
  logic [31:0] m_haddr = 32'h0, m_hwdata = 32'h0;
  logic [7:0]  exp_q[$];

  function automatic bit m_busy();
    return m_have || (m_gap > 0);
  endfunction

  initial begin : model
    bit g0, g1;
    forever begin
      @(posedge HCLK or negedge HRESETn);
      if (!HRESETn) begin
        m_have = 0; m_addr_sent = 0; m_last = 1; m_pulse = 0;
        m_gap = 0; m_wr = 0; m_err = 0; m_char = 8'h00;
        m_haddr = 32'h0; m_hwdata = 32'h0;
        exp_q.delete();
      end else if (!m_busy()) begin
        m_pulse = 0;
        g0 = req0_valid && (!req1_valid || m_last);
        g1 = req1_valid && (!req0_valid || !m_last);
        if (g0 || g1) begin
          m_have = 1; m_addr_sent = 0;
          m_char = g0 ? req0_data : req1_data;
          m_last = g1;
          m_haddr = VGA;
          exp_q.push_back(m_char);
        end
      end else begin
        m_pulse = 0;
        if (m_have && !m_addr_sent) begin
          if (HREADY) begin
            m_addr_sent = 1;
            m_hwdata = {24'h0, m_char};
          end
        end else if (m_have) begin
          if (HREADY) begin
            m_have = 0;
            m_gap = GAP;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (HRESP) begin
              if (m_err < 255) m_err++;
              m_pulse = 1;
            end else begin
              m_wr = (m_wr + 1) % 65536;
            end
          end
        end else begin
          m_gap--;
        end
      end
    end
  end

  // compare process: every cycle, on the falling edge
  always @(negedge HCLK) begin : compare
    bit e_g0, e_g1, e_idle;
    e_idle = !m_busy();
    e_g0 = e_idle && req0_valid && (!req1_valid || m_last);
    e_g1 = e_idle && req1_valid && (!req0_valid || !m_last);
    check("busy", busy, m_busy());
    check("req0_ready", req0_ready, e_g0);
    check("req1_ready", req1_ready, e_g1);
    check("htrans", HTRANS, (m_have && !m_addr_sent) ? 2'b10 : 2'b00);
    check("hwrite", HWRITE, m_have && !m_addr_sent);
    check("hsize", HSIZE, (m_have && !m_addr_sent) ? 3'b010 : 3'b000);
    check("haddr", HADDR, m_haddr);
    check("hwdata", HWDATA, m_hwdata);
    check("wr_count", wr_count, m_wr[15:0]);
    check("err_count", err_count, m_err[7:0]);
    check("err_pulse", err_pulse, m_pulse);
    if (m_have && m_addr_sent && exp_q.size() > 0)
      check("sb_char", HWDATA, {24'h0, exp_q[0]});
  end

  // driver tasks
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    HRESETn = 1'b0;
    cyc();
    cyc();
    HRESETn = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    bad++;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // reset state
    repeat (2) cyc();
    @(negedge HCLK);
    check("rst_busy", busy, 0);
    check("rst_htrans", HTRANS, 0);
    check("rst_haddr", HADDR, 0);
    check("rst_wr", wr_count, 0);

    // single write from req0, MIN_GAP=2
    cyc(); HRESETn = 1'b1; req0_valid = 1'b1; req0_data = 8'h41;
    @(negedge HCLK); check("t1_ready_c0", req0_ready, 1);
    cyc(); req0_valid = 1'b0;
    @(negedge HCLK); check("t1_htrans_c1", HTRANS, 2'b10); check("t1_haddr_c1", HADDR, 32'h5000_0000);
    cyc();
    @(negedge HCLK); check("t1_hwdata_c2", HWDATA, 32'h41);
    cyc(); req0_valid = 1'b1; req0_data = 8'h43;
    @(negedge HCLK); check("t1_ready_c3", req0_ready, 0);
    cyc();
    @(negedge HCLK); check("t1_ready_c4", req0_ready, 0);
    cyc();
    @(negedge HCLK); check("t1_ready_c5", req0_ready, 1); check("t1_wr_c5", wr_count, 1);
    cyc(); req0_valid = 1'b0;
    repeat (6) cyc();
    @(negedge HCLK); check("t1_wr_end", wr_count, 2);

    // both requesters continuous: alternation starting with req0
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h41; req1_valid = 1'b1; req1_data = 8'h42;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK);
      if (k % 5 == 0) begin
        check("rr_ready0", req0_ready, ((k / 5) % 2) == 0);
        check("rr_ready1", req1_ready, ((k / 5) % 2) == 1);
      end
      if (k % 5 == 2) check("rr_hwdata", HWDATA, ((k / 5) % 2 == 0) ? 32'h41 : 32'h42);
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) cyc();
    @(negedge HCLK); check("rr_wr", wr_count, 4);

    // wait states: 3 in address phase, 2 in data phase
    cyc(); req0_valid = 1'b1; req0_data = 8'h55;
    @(negedge HCLK); check("st_ready", req0_ready, 1);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      req0_valid = 1'b0;
      HREADY = (k == 4 || k == 7);
      @(negedge HCLK);
      if (k <= 4) begin
        check("st_htrans", HTRANS, 2'b10);
        check("st_haddr", HADDR, 32'h5000_0000);
      end else begin
        check("st_hwdata", HWDATA, 32'h55);
      end
      if (k == 6) check("st_wr_mid", wr_count, 4);
    end
    cyc(); HREADY = 1'b1;
    @(negedge HCLK); check("st_wr", wr_count, 5);
    repeat (4) cyc();

    // error response, then saturation
    cyc(); req1_valid = 1'b1; req1_data = 8'h66;
    @(negedge HCLK); check("er_ready", req1_ready, 1);
    cyc(); req1_valid = 1'b0;
    cyc(); HRESP = 1'b1;
    cyc(); HRESP = 1'b0;
    @(negedge HCLK);
    check("er_pulse", err_pulse, 1); check("er_cnt", err_count, 1); check("er_wr", wr_count, 5);
    cyc();
    @(negedge HCLK); check("er_pulse_off", err_pulse, 0);
    cyc(); HRESP = 1'b1; req1_valid = 1'b1;
    repeat (1510) cyc();
    @(negedge HCLK); check("er_sat", err_count, 255); check("er_sat_wr", wr_count, 5);
    cyc(); HRESP = 1'b0; req1_valid = 1'b0;
    repeat (6) cyc();

    // reset asserted during the data phase
    cyc(); req0_valid = 1'b1; req0_data = 8'h77;
    cyc(); req0_valid = 1'b0;
    cyc();
    @(negedge HCLK); check("rm_busy_data", busy, 1);
    #2 HRESETn = 1'b0;
    #1;
    check("rm_htrans", HTRANS, 0); check("rm_busy", busy, 0);
    check("rm_wr", wr_count, 0); check("rm_err", err_count, 0);
    cyc(); cyc(); HRESETn = 1'b1; req0_valid = 1'b1; req0_data = 8'h78;
    @(negedge HCLK); check("rm_ready", req0_ready, 1);
    cyc(); req0_valid = 1'b0;
    repeat (5) cyc();
    @(negedge HCLK); check("rm_wr_after", wr_count, 1);

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      cyc();
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_data  = 8'($urandom_range(0, 255));
      req1_data  = 8'($urandom_range(0, 255));
      HREADY     = ($urandom_range(0, 3) != 0);
      HRESP      = ($urandom_range(0, 15) == 0);
    end
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (12) cyc();

    // MIN_GAP=0 instance: one accept every third cycle
    do_reset();
    g0_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge HCLK);
      check("g0_ready", g0_r1_ready, (k % 3) == 0);
      cyc();
    end
    @(negedge HCLK); check("g0_wr", g0_wr_count, 10);
    g0_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_console_write_arbiter.md
Name: vga_console_write_arbiter

Overview:
- AHB-Lite master that shares the AHB VGA text-console peripheral between two byte-stream requesters (req0 = CPU bridge, req1 = debug/console source).
- Round-robin arbitration between requesters; one single-beat word write per accepted character.
- Enforces a programmable idle gap between writes so the VGA console has time to render and scroll.
- Sits between the requesters and the VGA slave port; counts transfers and errors for the lockstep/debug bench.

Parameters:
- VGA_ADDR, 32'h5000_0000, AHB address of the VGA console character register.
- MIN_GAP, 2, idle cycles inserted after each completed write (0 = none; legal range 0..255).

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a character
- req0_data  in  8  requester 0 character
- req0_ready  out  1  requester 0 character accepted this cycle
- req1_valid  in  1  requester 1 has a character
- req1_data  in  8  requester 1 character
- req1_ready  out  1  requester 1 character accepted this cycle
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type (IDLE=00, NONSEQ=10 only)
- HWRITE  out  1  AHB write
- HSIZE  out  3  AHB size (3'b010 during NONSEQ)
- HWDATA  out  32  AHB write data
- HREADY  in  1  AHB ready from slave/mux
- HRESP  in  1  AHB error response
- busy  out  1  high in any state other than IDLE
- wr_count  out  16  completed writes, wrapping
- err_count  out  8  error responses, saturating at 255
- err_pulse  out  1  one-cycle pulse per error response

Behaviour:
- Reset (async assert, sync release): state=IDLE; HADDR, HWDATA, HTRANS, HWRITE, HSIZE, wr_count, err_count, err_pulse = 0; last_grant=1, so req0 has priority first; gap counter = 0.
- States: IDLE, ADDR, DATA, GAP.
- IDLE:
  - grant = round-robin over valid requests; the requester not equal to last_grant wins a tie.
  - reqN_ready = (state==IDLE) && granted N; combinational, at most one high per cycle.
  - On valid&&ready at a clock edge: latch the character, set last_grant=N, go to ADDR.
- ADDR:
  - HTRANS=NONSEQ, HADDR=VGA_ADDR, HWRITE=1, HSIZE=010.
  - Hold all of these while HREADY=0.
  - On HREADY=1: go to DATA.
- DATA:
  - HTRANS=IDLE, HWRITE=0, HWDATA={24'b0,char}; HWDATA stays stable until HREADY=1.
  - On HREADY=1 with HRESP=0: wr_count++ (16-bit wrap).
  - On HREADY=1 with HRESP=1: err_count++ (saturating), err_pulse=1 for the next cycle only. No retry; the character is dropped and wr_count is unchanged.
  - Next state: GAP if MIN_GAP>0, else IDLE.
- GAP:
  - Counter loads MIN_GAP-1 on entry and decrements; go to IDLE when it reaches 0.
  - All outputs idle and both readys low.
- HADDR and HWDATA hold their last values outside ADDR/DATA; HTRANS is never NONSEQ outside ADDR.
- Latency with HREADY=1 and MIN_GAP=0:
  - accept at cycle 0, NONSEQ in cycle 1, data phase in cycle 2, IDLE in cycle 3.
  - Next accept is possible in cycle 3, i.e. one write per 3 cycles.
- Requester changing data or dropping valid while not ready: ignored, nothing latched.
- Reset mid-transfer: returns immediately to IDLE with HTRANS=00. The in-flight character is lost; no ready is reissued for it.
- busy=1 in ADDR, DATA and GAP.

Test Plan:
- Reset, then req0 sends 8'h41 with HREADY=1, MIN_GAP=2: req0_ready in cycle 0; HTRANS=10 and HADDR=32'h5000_0000 in cycle 1; HWDATA=32'h41 in cycle 2; next accept in cycle 5; wr_count=1.
- Both requesters valid continuously (req0 'A', req1 'B'): grants alternate 0,1,0,1 starting with req0; after 4 writes HWDATA sequence is 41,42,41,42.
- HREADY low 3 cycles during ADDR and 2 cycles during DATA: HADDR/HTRANS held through the ADDR stall, HWDATA stable through the DATA stall; exactly one wr_count increment.
- HRESP=1 with HREADY=1 in DATA: err_pulse high 1 cycle, err_count=1, wr_count unchanged; 300 error responses leave err_count=255.
- HRESETn asserted during DATA: HTRANS=00 and busy=0 immediately; counters cleared; the next request is accepted normally after release.
- MIN_GAP=0 with req1 continuous: accepts every 3rd cycle; 65536 writes wrap wr_count to 0.
